// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
package spi_ctrl_pkg;

  // Default parameter values for the controller and its sub-blocks.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SS_W   = 8;
  localparam int DEF_DIV_W  = 8;

  // SPI mode 0: SCLK idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Transfer sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_CS_SETUP = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_CS_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// FIFO read side and SPI pad signals of the transfer sequencer.
interface spi_xfer_ctrl_if
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SS_W   = DEF_SS_W
);

  // Tx data FIFO read port
  logic              tx_empty;
  logic [DATA_W-1:0] tx_dout;
  logic              tx_rd_en;

  // Slave-select FIFO read port
  logic              ss_empty;
  logic [DATA_W-1:0] ss_dout;
  logic              ss_rd_en;

  // SPI pads
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic [SS_W-1:0]   cs_n;

  // Controller side: pops the FIFOs and drives the pads.
  modport master (
    input  tx_empty, tx_dout, ss_empty, ss_dout, miso,
    output tx_rd_en, ss_rd_en, sclk, mosi, cs_n
  );

  // Environment side: FIFOs and the SPI slave.
  modport slave (
    output tx_empty, tx_dout, ss_empty, ss_dout, miso,
    input  tx_rd_en, ss_rd_en, sclk, mosi, cs_n
  );

endinterface

// File: rtl/spi_xfer_ctrl_clk_div.sv
// Half-period timer: a down-counter that ticks once every n+1 enabled cycles.
module spi_clk_div
  import spi_ctrl_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] n,
  output logic             half_tick
);

  logic [DIV_W-1:0] cnt_reg;

  // The tick fires on the last cycle of each half-period.
  assign half_tick = en && !load && (cnt_reg == '0);

  // Load restarts the count; when enabled the counter reloads itself on every tick.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= n;
    end else if (en) begin
      if (cnt_reg == '0) begin
        cnt_reg <= n;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Drains the Tx and SS FIFOs in pairs and runs one mode-0 SPI transfer per pair.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SS_W   = DEF_SS_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  spi_xfer_ctrl_if.master    bus,
  input  logic [DIV_W-1:0]   clk_div,
  output logic               busy,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_valid,
  output logic               err_ss
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            state_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [SS_W-1:0]   cs_sel_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic              sclk_reg;
  logic              mosi_reg;
  logic [SS_W-1:0]   cs_n_reg;
  logic              busy_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              err_ss_reg;

  logic              pop;
  logic [SS_W-1:0]   ss_sel;
  logic [DIV_W-1:0]  div_n;
  logic              div_load;
  logic              div_en;
  logic              half_tick;
  logic              sample_edge;

  // Both FIFOs pop together, and never while reset is held so no word is lost to it.
  assign pop          = ARESETN && (state_reg == ST_IDLE) && !bus.tx_empty && !bus.ss_empty;
  assign bus.tx_rd_en = pop;
  assign bus.ss_rd_en = pop;

  assign ss_sel = bus.ss_dout[SS_W-1:0];

  // Upper SS word bits carry no select information.
  if (SS_W < DATA_W) begin : g_ss_hi
    logic ss_hi_unused;
    assign ss_hi_unused = ^bus.ss_dout[DATA_W-1:SS_W];
  end

  // The divider is loaded with the live clk_div in FETCH, then runs on the latched copy.
  assign div_load = (state_reg == ST_FETCH);
  assign div_en   = (state_reg == ST_CS_SETUP) || (state_reg == ST_SHIFT) ||
                    (state_reg == ST_CS_HOLD);
  assign div_n    = div_load ? clk_div : div_reg;

  // The next SCLK toggle is a sampling edge when it leaves the idle level (CPHA=0).
  assign sample_edge = (sclk_reg == SPI_CPOL) ^ SPI_CPHA;

  spi_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .load      (div_load),
    .en        (div_en),
    .n         (div_n),
    .half_tick (half_tick)
  );

  // Transfer sequencer with all pad and status outputs registered.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_reg    <= ST_IDLE;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      cs_sel_reg   <= '0;
      div_reg      <= '0;
      bit_cnt_reg  <= '0;
      sclk_reg     <= SPI_CPOL;
      mosi_reg     <= 1'b0;
      cs_n_reg     <= '1;
      busy_reg     <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      err_ss_reg   <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      err_ss_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            busy_reg  <= 1'b1;
            state_reg <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          tx_shift_reg <= bus.tx_dout;
          cs_sel_reg   <= ss_sel;
          div_reg      <= clk_div;
          bit_cnt_reg  <= '0;
          if (ss_sel == '0) begin
            // Nothing selected: report it and drop the pair without touching the bus.
            err_ss_reg <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= ST_IDLE;
          end else begin
            state_reg  <= ST_CS_SETUP;
          end
        end

        ST_CS_SETUP: begin
          cs_n_reg <= ~cs_sel_reg;
          mosi_reg <= tx_shift_reg[DATA_W-1];
          if (half_tick) begin
            state_reg <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (half_tick) begin
            sclk_reg <= ~sclk_reg;
            if (sample_edge) begin
              rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], bus.miso};
            end else if (bit_cnt_reg == LAST_BIT) begin
              // Final falling edge: keep the last bit on MOSI through the hold time.
              state_reg <= ST_CS_HOLD;
            end else begin
              bit_cnt_reg  <= bit_cnt_reg + 1'b1;
              tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
              mosi_reg     <= tx_shift_reg[DATA_W-2];
            end
          end
        end

        ST_CS_HOLD: begin
          if (half_tick) begin
            cs_n_reg     <= '1;
            mosi_reg     <= 1'b0;
            rx_data_reg  <= rx_shift_reg;
            rx_valid_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sclk = sclk_reg;
  assign bus.mosi = mosi_reg;
  assign bus.cs_n = cs_n_reg;
  assign busy     = busy_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign err_ss   = err_ss_reg;

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Sequencer that drains the Tx data FIFO and the slave-select FIFO filled by the AXI write slave and runs one SPI mode-0 transfer per word pair. It pops one 32-bit Tx word and one SS word together, asserts the selected chip select, and shifts 32 bits MSB-first on SCLK/MOSI. It captures 32 MISO bits and presents them as a single-cycle receive strobe. It sits between the two write-side FIFOs and the SPI pads.

## Interface
Parameters:
- DATA_W, 32, transfer width in bits; also the FIFO word width.
- SS_W, 8, number of chip-select lines; taken from SS word bits [SS_W-1:0].
- DIV_W, 8, width of the clock-divider input.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, synchronous, active-low; clock ACLK.
- tx_empty  in  1  Tx FIFO empty.
- tx_dout  in  DATA_W  Tx FIFO read data; valid one cycle after tx_rd_en.
- tx_rd_en  out  1  Tx FIFO pop.
- ss_empty  in  1  SS FIFO empty.
- ss_dout  in  DATA_W  SS FIFO read data; valid one cycle after ss_rd_en.
- ss_rd_en  out  1  SS FIFO pop.
- clk_div  in  DIV_W  SCLK half-period is clk_div+1 ACLK cycles.
- miso  in  1  serial input, already synchronised.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  serial output.
- cs_n  out  SS_W  active-low chip selects.
- busy  out  1  high in every state except IDLE.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- err_ss  out  1  one-cycle strobe when an SS word selects nothing.

## Operation
- FSM states: IDLE, FETCH, CS_SETUP, SHIFT, CS_HOLD.
- IDLE:
  - tx_rd_en = ss_rd_en = !tx_empty && !ss_empty. Both are combinational and pop together; a lone FIFO is never popped.
  - When they pop, go to FETCH.
- FETCH:
  - Latch tx_dout into the shift register, ss_dout[SS_W-1:0] into the cs register, and clk_div into the divider register.
  - If the latched SS bits are all zero: pulse err_ss, do not touch cs_n, return to IDLE.
  - Otherwise go to CS_SETUP.
  - Multi-hot SS values are legal and drive several cs_n lines low.
- CS_SETUP:
  - cs_n = ~ss_latched; mosi = tx bit DATA_W-1.
  - Lasts one half-period, then go to SHIFT.
- SHIFT (mode 0):
  - sclk toggles every half-period, 2*DATA_W half-periods in total.
  - Each rising edge samples miso into the LSB of the rx shift register.
  - Each falling edge shifts mosi to the next lower bit. No shift follows the final falling edge.
  - After the last falling edge go to CS_HOLD.
- CS_HOLD:
  - sclk low, cs_n still asserted, for one half-period.
  - Then cs_n goes all ones, rx_data is loaded, rx_valid pulses, and the FSM returns to IDLE.
- clk_div changes mid-transfer are ignored until the next FETCH.
- Reset, including mid-transfer:
  - On the next edge: state IDLE, sclk 0, mosi 0, cs_n all ones, busy 0, rx_valid 0, err_ss 0, rx_data 0.
  - The divider counter clears.
  - A popped but unfinished word is lost.

## Timing
- With N = latched clk_div, one transfer takes 1 (IDLE pop) + 1 (FETCH) + (N+1) + 2*DATA_W*(N+1) + (N+1) cycles. For N=0, DATA_W=32 that is 68 cycles.
- Minimum cs_n high gap between back-to-back transfers is 3 cycles (CS_HOLD exit, IDLE, FETCH).
- rx_valid rises in the same cycle cs_n deasserts.
- All outputs except tx_rd_en and ss_rd_en are registered.
- A FIFO going empty mid-transfer has no effect. A FIFO becoming non-empty during a transfer is served on the next IDLE cycle.

## Structure
- Package spi_ctrl_pkg holds:
  - the state enum;
  - the default parameter values;
  - the SPI mode constant (CPOL=0, CPHA=0).
- Sub-module spi_clk_div: a DIV_W down-counter that emits a one-cycle half_tick every N+1 cycles. It has load and enable inputs and is reset to 0.

## Test plan
- Single transfer, N=0: tx=0xA5A5_0F0F, ss=0x01, miso looped to mosi. Required: cs_n=0xFE for the transfer, 32 rising sclk edges, rx_data=0xA5A5_0F0F, rx_valid in cycle 68.
- Divider: N=3, tx=0x8000_0001. Required: sclk half-period 4 cycles, mosi high for the first and last bits only, total 1+1+4+256+4=266 cycles.
- Empty gating: Tx FIFO holds 2 words, SS FIFO holds 0. Required: no pops and busy=0. Write one SS word: exactly one transfer, one Tx word remains.
- Bad select: ss=0x00. Required: both FIFOs popped, err_ss pulses once, cs_n stays 0xFF, no sclk edges, no rx_valid.
- Back-to-back: two word pairs queued. Required: second cs_n assertion exactly 3 cycles after the first deassertion, two rx_valid strobes.
- Reset mid-SHIFT: deassert ARESETN after bit 10. Required: next edge sclk=0, cs_n=0xFF, busy=0. After release, the next queued pair transfers normally.
